pipe_gen: RTL and testbench

Obstacle-column generator feeding the `action` stage of the Flappy Bird game. On each enable it produces the next 8-row column to be shifted into the playfield: either empty, or a pipe wall with a pseudo-random gap. It uses the codebase's enable/done handshake, so the top-level state machine can sequence it like the `get_input`, `action` and `display` stages.

---
 rtl/pipe_gen.sv | 117 +++++++++++
 tb/tb_pipe_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_gen.sv
// -----------------------------------------------------------------------------
// pipe_gen
//   Obstacle-column generator for the Flappy Bird playfield. Each request on
//   the enable/done handshake produces one gs-row column. One column in every
//   `spacing` requests is a pipe wall with a pseudo-random gap of `gap` rows.
//   All other columns are empty. An 8-bit Fibonacci LFSR, which advances once
//   per request, picks the gap position.
//
// Ports
//   clk_i      : clock; all state changes on the rising edge
//   reset_i    : asynchronous active-high reset
//   e_pipe_i   : request (enable) from the top-level FSM
//   col_o      : generated column, bit i = row i, 1 = wall
//   d_pipe_o   : done; col_o is valid while high
//   pipe_cnt_o : number of pipe columns emitted, saturating at 255
// -----------------------------------------------------------------------------
module pipe_gen #(
  parameter int         gs      = 8,
  parameter int         gap     = 3,
  parameter int         spacing = 4,
  parameter logic [7:0] seed    = 8'hA5
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          e_pipe_i,
  output logic [gs-1:0] col_o,
  output logic          d_pipe_o,
  output logic [7:0]    pipe_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_BUILD, S_DONE} state_t;

  localparam logic [7:0] SP_LAST = 8'(spacing - 1);

  state_t        r_state;
  logic [7:0]    r_lfsr;
  logic [7:0]    r_sp_cnt;
  logic [7:0]    r_pcnt;
  logic [gs-1:0] r_col;
  logic          r_done;

  logic [7:0]    w_lfsr_nxt;
  logic [gs-1:0] w_pipe_col;

  // x^8+x^6+x^5+x^4+1, shift left; a nonzero seed never reaches zero.
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Raw positions that would push the gap past the top row wrap to the bottom.
  function automatic int gap_pos(input logic [2:0] raw);
    int r;
    r = int'(raw);
    if (r <= gs - gap) return r;
    return r - (gs - gap + 1);
  endfunction

  function automatic logic [gs-1:0] pipe_col(input int pos);
    logic [gs-1:0] c;
    c = '1;
    for (int i = 0; i < gs; i++) begin
      if (i >= pos && i < pos + gap) c[i] = 1'b0;
    end
    return c;
  endfunction

  assign w_lfsr_nxt = lfsr_step(r_lfsr);
  // Evaluated in BUILD, when r_lfsr already holds the advanced value.
  assign w_pipe_col = pipe_col(gap_pos(r_lfsr[2:0]));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= S_IDLE;
      r_lfsr   <= seed;
      r_sp_cnt <= 8'd0;
      r_pcnt   <= 8'd0;
      r_col    <= '0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (e_pipe_i) r_state <= S_STEP;
        end
        S_STEP: begin
          r_lfsr  <= w_lfsr_nxt;
          r_state <= S_BUILD;
        end
        S_BUILD: begin
          if (r_sp_cnt == SP_LAST) begin
            r_col    <= w_pipe_col;
            r_sp_cnt <= 8'd0;
            if (r_pcnt != 8'hFF) r_pcnt <= r_pcnt + 8'd1;
          end else begin
            r_col    <= '0;
            r_sp_cnt <= r_sp_cnt + 8'd1;
          end
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          // Hold the result until the requester releases the enable.
          if (!e_pipe_i) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign col_o      = r_col;
  assign d_pipe_o   = r_done;
  assign pipe_cnt_o = r_pcnt;

endmodule

// File: tb/tb_pipe_gen.sv
module tb_pipe_gen;

  localparam int GS      = 8;
  localparam int GAP     = 3;
  localparam int SPACING = 4;

  logic          clk;
  logic          reset_i;
  logic          e_pipe_i;
  logic [GS-1:0] col_o;
  logic          d_pipe_o;
  logic [7:0]    pipe_cnt_o;

  pipe_gen #(.gs(GS), .gap(GAP), .spacing(SPACING), .seed(8'hA5)) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .e_pipe_i  (e_pipe_i),
    .col_o     (col_o),
    .d_pipe_o  (d_pipe_o),
    .pipe_cnt_o(pipe_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: requests completed since reset, LFSR, outputs.
  logic [7:0] m_lfsr;
  int         m_req;
  int         m_pcnt;
  logic [7:0] m_col;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_next(input logic [7:0] x);
    logic fb;
    fb = x[7] ^ x[5] ^ x[4] ^ x[3];
    return 8'((x << 1) | {7'd0, fb});
  endfunction

  function automatic logic [7:0] m_pipe(input logic [7:0] l);
    int raw, pos;
    raw = int'(l) % 8;
    pos = (raw <= GS - GAP) ? raw : raw - (GS - GAP + 1);
    return 8'(32'hFF & ~(((1 << GAP) - 1) << pos));
  endfunction

  task automatic model_reset();
    m_lfsr = 8'hA5;
    m_req  = 0;
    m_pcnt = 0;
    m_col  = 8'h00;
  endtask

  task automatic model_request();
    m_lfsr = m_next(m_lfsr);
    m_req++;
    if (m_req % SPACING == 0) begin
      m_col = m_pipe(m_lfsr);
      if (m_pcnt < 255) m_pcnt++;
    end else begin
      m_col = 8'h00;
    end
  endtask

  // Called at a negedge with the DUT idle. Returns at a negedge, DUT idle.
  task automatic do_req(input int hold, input bit pulse);
    int         edges;
    logic [7:0] l_snap;
    e_pipe_i = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    if (pulse) e_pipe_i = 1'b0;
    while (!d_pipe_o && edges < 8) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    model_request();
    check("latency", edges, 3);
    check("done_hi", d_pipe_o, 1'b1);
    check("col", col_o, m_col);
    check("pipe_cnt", pipe_cnt_o, m_pcnt);
    if (pulse) begin
      @(posedge clk);
      @(negedge clk);
      check("pulse_done_len", d_pipe_o, 1'b0);
    end else begin
      l_snap = dut.r_lfsr;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk);
        @(negedge clk);
        check("hold_done", d_pipe_o, 1'b1);
        check("hold_col", col_o, m_col);
      end
      if (hold > 0) check("hold_lfsr", dut.r_lfsr, l_snap);
      e_pipe_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("done_fall", d_pipe_o, 1'b0);
    end
  endtask

  initial begin
    reset_i  = 1'b0;
    e_pipe_i = 1'b0;
    model_reset();

    // Scenario 1: asynchronous reset seen before any clock edge.
    #2 reset_i = 1'b1;
    #1;
    check("rst_col", col_o, 8'h00);
    check("rst_done", d_pipe_o, 1'b0);
    check("rst_cnt", pipe_cnt_o, 8'd0);
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_col", col_o, 8'h00);
    check("idle_done", d_pipe_o, 1'b0);
    check("idle_cnt", pipe_cnt_o, 8'd0);

    // Scenario 2: first pipe period.
    for (int r = 0; r < 3; r++) begin
      do_req(0, 1'b0);
      check("p1_empty", col_o, 8'h00);
    end
    do_req(0, 1'b0);
    check("p1_pipe_col", col_o, 8'h8F);
    check("p1_lfsr", dut.r_lfsr, 8'h54);
    check("p1_cnt", pipe_cnt_o, 8'd1);

    // Scenario 3: enable held 10 cycles after done.
    do_req(10, 1'b0);
    // Scenario 4: one-cycle request pulse.
    do_req(0, 1'b1);
    do_req(0, 1'b0);
    do_req(0, 1'b0);
    check("p2_cnt", pipe_cnt_o, 8'd2);
    // col_o must persist through IDLE.
    repeat (3) @(negedge clk);
    check("idle_hold_col", col_o, m_col);

    // Scenario 5: reset in BUILD of request 4 of a fresh period.
    for (int r = 0; r < 3; r++) do_req(0, 1'b0);
    e_pipe_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 reset_i = 1'b1;
    #1;
    check("mid_rst_col", col_o, 8'h00);
    check("mid_rst_cnt", pipe_cnt_o, 8'd0);
    check("mid_rst_lfsr", dut.r_lfsr, 8'hA5);
    @(negedge clk);
    e_pipe_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b0;
    check("mid_rst_nopipe", pipe_cnt_o, 8'd0);
    check("mid_rst_done", d_pipe_o, 1'b0);
    model_reset();
    for (int r = 0; r < 3; r++) do_req(0, 1'b0);
    do_req(0, 1'b0);
    check("replay_col", col_o, 8'h8F);
    check("replay_lfsr", dut.r_lfsr, 8'h54);
    check("replay_cnt", pipe_cnt_o, 8'd1);

    // Scenario 6: long randomized run with saturation.
    while (m_req < 1100) begin
      int         lo;
      logic [7:0] inv;
      do_req($urandom_range(0, 2), ($urandom_range(0, 3) == 0));
      check("lfsr_nonzero", (dut.r_lfsr == 8'h00), 1'b0);
      if (m_req % SPACING == 0) begin
        inv = ~col_o;
        lo  = 8;
        for (int i = 7; i >= 0; i--) if (inv[i]) lo = i;
        check("gap_count", $countones(inv), GAP);
        check("gap_pos_le5", (lo <= GS - GAP), 1'b1);
        check("gap_contig", (inv >> lo) & 8'h07, 8'h07);
      end
      if (m_req == 1019) check("cnt_254", pipe_cnt_o, 8'd254);
      if (m_req >= 1020) check("cnt_sat", pipe_cnt_o, 8'd255);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
